sipo_load_ctrl: RTL and testbench

Sequencer for the parameterized serial-in/parallel-out shift register (`dff_param`). It accepts a SIZE-bit word over a valid/ready handshake and drives the register's enable and serial-in MSB-first for exactly SIZE cycles. It then reads the parallel output back, compares it with the word, and returns the captured word plus a mismatch flag over a second valid/ready handshake. It sits between a word-wide producer and the shift-register datapath.

---
 rtl/sipo_ctrl_pkg.sv | 16 +
 rtl/dff_param.sv | 27 ++
 rtl/sipo_bit_counter.sv | 33 +++
 rtl/sipo_load_top.sv | 45 ++++
 rtl/sipo_load_ctrl.sv | 104 ++++++++++
 tb/tb_sipo_load_ctrl.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out load sequencer:
// FSM state encoding and the bit-counter width helper.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/dff_param.sv
// Parameterized serial-in/parallel-out shift register: shifts si into the LSB
// on every enabled rising edge.
module dff_param #(
  parameter int unsigned SIZE = 16
) (
  input  logic            dff_param_port_clk,
  input  logic            dff_param_port_rst,
  input  logic            dff_param_port_en,
  input  logic            dff_param_port_si,
  output logic [SIZE-1:0] dff_param_port_p
);

  logic [SIZE-1:0] p_q, p_d;

  always_comb begin
    p_d = p_q;
    if (dff_param_port_en) p_d = {p_q[SIZE-2:0], dff_param_port_si};
  end

  always_ff @(posedge dff_param_port_clk or posedge dff_param_port_rst) begin
    if (dff_param_port_rst) p_q <= '0;
    else                    p_q <= p_d;
  end

  assign dff_param_port_p = p_q;

endmodule

// File: rtl/sipo_bit_counter.sv
// Up-counter with synchronous clear and enable; saturates at LAST and flags
// terminal count so the shift sequence can never run past the word width.
module sipo_bit_counter #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAST = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == W'(LAST));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sipo_load_top.sv
// Integration wrapper: load sequencer tied to its shift-register datapath.
module sipo_load_top #(
  parameter int unsigned SIZE = 16
) (
  input  logic            sipo_load_top_port_clk,
  input  logic            sipo_load_top_port_rst,
  input  logic            sipo_load_top_port_in_valid,
  output logic            sipo_load_top_port_in_ready,
  input  logic [SIZE-1:0] sipo_load_top_port_in_data,
  input  logic            sipo_load_top_port_abort,
  output logic            sipo_load_top_port_out_valid,
  input  logic            sipo_load_top_port_out_ready,
  output logic [SIZE-1:0] sipo_load_top_port_out_data,
  output logic            sipo_load_top_port_out_err
);

  logic            sr_en;
  logic            sr_si;
  logic [SIZE-1:0] sr_p;

  sipo_load_ctrl #(.SIZE(SIZE)) u_ctrl (
    .sipo_load_ctrl_port_clk       (sipo_load_top_port_clk),
    .sipo_load_ctrl_port_rst       (sipo_load_top_port_rst),
    .sipo_load_ctrl_port_in_valid  (sipo_load_top_port_in_valid),
    .sipo_load_ctrl_port_in_ready  (sipo_load_top_port_in_ready),
    .sipo_load_ctrl_port_in_data   (sipo_load_top_port_in_data),
    .sipo_load_ctrl_port_abort     (sipo_load_top_port_abort),
    .sipo_load_ctrl_port_sr_en     (sr_en),
    .sipo_load_ctrl_port_sr_si     (sr_si),
    .sipo_load_ctrl_port_sr_p      (sr_p),
    .sipo_load_ctrl_port_out_valid (sipo_load_top_port_out_valid),
    .sipo_load_ctrl_port_out_ready (sipo_load_top_port_out_ready),
    .sipo_load_ctrl_port_out_data  (sipo_load_top_port_out_data),
    .sipo_load_ctrl_port_out_err   (sipo_load_top_port_out_err)
  );

  dff_param #(.SIZE(SIZE)) u_sr (
    .dff_param_port_clk (sipo_load_top_port_clk),
    .dff_param_port_rst (sipo_load_top_port_rst),
    .dff_param_port_en  (sr_en),
    .dff_param_port_si  (sr_si),
    .dff_param_port_p   (sr_p)
  );

endmodule

// File: rtl/sipo_load_ctrl.sv
// Loads a word MSB-first into the attached shift register, reads the parallel
// output back, and returns it with a mismatch flag over a valid/ready port.
module sipo_load_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic            sipo_load_ctrl_port_clk,
  input  logic            sipo_load_ctrl_port_rst,
  input  logic            sipo_load_ctrl_port_in_valid,
  output logic            sipo_load_ctrl_port_in_ready,
  input  logic [SIZE-1:0] sipo_load_ctrl_port_in_data,
  input  logic            sipo_load_ctrl_port_abort,
  output logic            sipo_load_ctrl_port_sr_en,
  output logic            sipo_load_ctrl_port_sr_si,
  input  logic [SIZE-1:0] sipo_load_ctrl_port_sr_p,
  output logic            sipo_load_ctrl_port_out_valid,
  input  logic            sipo_load_ctrl_port_out_ready,
  output logic [SIZE-1:0] sipo_load_ctrl_port_out_data,
  output logic            sipo_load_ctrl_port_out_err
);

  localparam int unsigned CW = cnt_width(SIZE);

  state_e          state_q, state_d;
  logic [SIZE-1:0] hold_q, hold_d;
  logic [SIZE-1:0] out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic [CW-1:0]   bit_idx;
  logic            in_shift;

  assign in_shift = (state_q == SHIFT);

  // Counter is held at zero outside SHIFT, so every load starts from bit 0.
  sipo_bit_counter #(
    .W    (CW),
    .LAST (SIZE - 1)
  ) u_cnt (
    .clk (sipo_load_ctrl_port_clk),
    .rst (sipo_load_ctrl_port_rst),
    .clr (!in_shift),
    .en  (in_shift),
    .cnt (cnt),
    .tc  (cnt_last)
  );

  assign bit_idx = CW'(SIZE - 1) - cnt;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (sipo_load_ctrl_port_in_valid) begin
          hold_d  = sipo_load_ctrl_port_in_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sipo_load_ctrl_port_abort) state_d = IDLE;
        else if (cnt_last)             state_d = CHECK;
      end
      CHECK: begin
        if (sipo_load_ctrl_port_abort) begin
          state_d = IDLE;
        end else begin
          out_data_d = sipo_load_ctrl_port_sr_p;
          out_err_d  = (sipo_load_ctrl_port_sr_p != hold_q);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (sipo_load_ctrl_port_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sipo_load_ctrl_port_clk or posedge sipo_load_ctrl_port_rst) begin
    if (sipo_load_ctrl_port_rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign sipo_load_ctrl_port_in_ready  = (state_q == IDLE);
  assign sipo_load_ctrl_port_sr_en     = in_shift;
  assign sipo_load_ctrl_port_sr_si     = in_shift & hold_q[bit_idx];
  assign sipo_load_ctrl_port_out_valid = (state_q == DONE);
  assign sipo_load_ctrl_port_out_data  = out_data_q;
  assign sipo_load_ctrl_port_out_err   = out_err_q;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Directed bench for sipo_load_ctrl driving a dff_param through a fault-capable
// readback path, with the integration wrapper alongside as a clean reference.
module tb_sipo_load_ctrl;

  localparam int unsigned SIZE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            abort = 1'b0;
  logic            sr_en, sr_si;
  logic [SIZE-1:0] sr_p_raw, sr_p;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] out_data;
  logic            out_err;
  logic            stuck = 1'b0;

  logic            top_in_ready, top_out_valid, top_out_err;
  logic [SIZE-1:0] top_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Bit 0 of the readback can be forced to 0 to emulate a broken datapath.
  assign sr_p = sr_p_raw & ~{{(SIZE-1){1'b0}}, stuck};

  sipo_load_ctrl #(.SIZE(SIZE)) u_dut (
    .sipo_load_ctrl_port_clk       (clk),
    .sipo_load_ctrl_port_rst       (rst),
    .sipo_load_ctrl_port_in_valid  (in_valid),
    .sipo_load_ctrl_port_in_ready  (in_ready),
    .sipo_load_ctrl_port_in_data   (in_data),
    .sipo_load_ctrl_port_abort     (abort),
    .sipo_load_ctrl_port_sr_en     (sr_en),
    .sipo_load_ctrl_port_sr_si     (sr_si),
    .sipo_load_ctrl_port_sr_p      (sr_p),
    .sipo_load_ctrl_port_out_valid (out_valid),
    .sipo_load_ctrl_port_out_ready (out_ready),
    .sipo_load_ctrl_port_out_data  (out_data),
    .sipo_load_ctrl_port_out_err   (out_err)
  );

  dff_param #(.SIZE(SIZE)) u_sr (
    .dff_param_port_clk (clk),
    .dff_param_port_rst (rst),
    .dff_param_port_en  (sr_en),
    .dff_param_port_si  (sr_si),
    .dff_param_port_p   (sr_p_raw)
  );

  sipo_load_top #(.SIZE(SIZE)) u_top (
    .sipo_load_top_port_clk       (clk),
    .sipo_load_top_port_rst       (rst),
    .sipo_load_top_port_in_valid  (in_valid),
    .sipo_load_top_port_in_ready  (top_in_ready),
    .sipo_load_top_port_in_data   (in_data),
    .sipo_load_top_port_abort     (abort),
    .sipo_load_top_port_out_valid (top_out_valid),
    .sipo_load_top_port_out_ready (out_ready),
    .sipo_load_top_port_out_data  (top_out_data),
    .sipo_load_top_port_out_err   (top_out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until out_valid, returning the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("valid_seen", 32'(out_valid), 32'd1);
  endtask

  function automatic logic [SIZE-1:0] word_of(input int k);
    return SIZE'(k * 40503 + 7);
  endfunction

  initial begin
    int n, en_cnt, flaws;
    logic [SIZE-1:0] seq;
    logic [SIZE-1:0] exp_w;
    logic [SIZE-1:0] q[$];
    int acc, res, last, cyc, bad_iv, bad_data, bad_err;
    logic acc_now;

    // Reset
    repeat (10) tick();
    chk("rst_in_ready_hold", 32'(in_ready), 32'd1);
    chk("rst_sr_en_hold", 32'(sr_en), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sr_en", 32'(sr_en), 32'd0);
    chk("rst_sr_si", 32'(sr_si), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // Basic load of A5C3
    in_valid = 1'b1; in_data = 16'hA5C3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; en_cnt = 0; seq = '0;
    while (!out_valid && n < 60) begin
      if (sr_en) begin
        en_cnt++;
        seq = {seq[SIZE-2:0], sr_si};
      end
      tick();
      n++;
    end
    chk("basic_si_seq", 32'(seq), 32'hA5C3);
    chk("basic_en_cycles", 32'(en_cnt), 32'd16);
    chk("basic_valid_latency", 32'(n), 32'd17);
    chk("basic_out_data", 32'(out_data), 32'hA5C3);
    chk("basic_out_err", 32'(out_err), 32'd0);
    chk("basic_top_data", 32'(top_out_data), 32'hA5C3);
    tick();
    chk("basic_back_idle", 32'(in_ready), 32'd1);

    // Back-pressure, with abort ignored in DONE and a pending word waiting
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C5A;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    in_valid = 1'b1; in_data = 16'h1234; abort = 1'b1;
    flaws = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== 16'h3C5A || out_err !== 1'b0 || in_ready !== 1'b0)
        flaws++;
      tick();
    end
    abort = 1'b0;
    chk("bp_stall_stable", 32'(flaws), 32'd0);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_ack_idle", 32'(in_ready), 32'd1);
    chk("bp_ack_no_accept", 32'(sr_en), 32'd0);
    chk("bp_ack_valid_low", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(sr_en), 32'd1);
    chk("bp_next_in_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    chk("bp_next_latency", 32'(n), 32'd17);
    chk("bp_next_data", 32'(out_data), 32'h1234);
    tick();

    // Abort at cnt=5 while loading FFFF over prior contents 1234
    in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("abort_in_shift", 32'(sr_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sr_en", 32'(sr_en), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd1);
    chk("abort_sr_low5", 32'(sr_p_raw[4:0]), 32'h1F);
    chk("abort_sr_full", 32'(sr_p_raw), 32'h8D3F);
    flaws = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) flaws++;
      tick();
    end
    chk("abort_no_result", 32'(flaws), 32'd0);

    // Abort on the last shift cycle wins over the move to CHECK
    in_valid = 1'b1; in_data = 16'h00FF;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("abort_last_in_shift", 32'(sr_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_last_idle", 32'(in_ready), 32'd1);
    flaws = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) flaws++;
      tick();
    end
    chk("abort_last_no_result", 32'(flaws), 32'd0);

    // Corrupted readback
    stuck = 1'b1;
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("corrupt_err", 32'(out_err), 32'd1);
    chk("corrupt_data", 32'(out_data), 32'h0000);
    chk("corrupt_top_err", 32'(top_out_err), 32'd0);
    chk("corrupt_top_data", 32'(top_out_data), 32'h0001);
    stuck = 1'b0;
    tick();

    // Stream 1000 words with out_ready held high
    acc = 0; res = 0; last = -1; cyc = 0; bad_iv = 0; bad_data = 0; bad_err = 0;
    in_valid = 1'b1; in_data = word_of(0);
    while (res < 1000 && cyc < 25000) begin
      acc_now = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        acc_now = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) bad_data++;
        else begin
          exp_w = q.pop_front();
          if (out_data !== exp_w) bad_data++;
        end
        if (out_err !== 1'b0) bad_err++;
        if (last >= 0 && (cyc - last) != 19) bad_iv++;
        last = cyc;
        res++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        acc++;
        if (acc < 1000) in_data = word_of(acc);
        else            in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("stream_results", 32'(res), 32'd1000);
    chk("stream_interval", 32'(bad_iv), 32'd0);
    chk("stream_data", 32'(bad_data), 32'd0);
    chk("stream_err", 32'(bad_err), 32'd0);
    tick();

    // Reset during SHIFT drops enable without a clock edge
    in_valid = 1'b1; in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("midrst_in_shift", 32'(sr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sr_en_async", 32'(sr_en), 32'd0);
    chk("midrst_in_ready_async", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
